// File: rtl/pcie_tl_pkg.sv
// Shared constants and helpers for the PCIe transaction-layer FIFOs and their state machine.
package pcie_tl_pkg;

    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int NUM_FIFOS       = 8;

    // Occupancy update selected by the accepted push/pop combination.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Maps accepted push/pop to a count operation; both or neither leave the count alone.
    function automatic cnt_op_e count_op(input logic push_acc, input logic pop_acc);
        cnt_op_e op;
        case ({push_acc, pop_acc})
            2'b10:   op = CNT_INC;
            2'b01:   op = CNT_DEC;
            default: op = CNT_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for one channel FIFO: synchronous write port, registered read port.
module fifo_mem
    import pcie_tl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write port: contents are deliberately not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: register the addressed word on a read, otherwise hold the last word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbral.sv
// Per-virtual-channel FIFO with occupancy count, threshold flags and sticky error.
module fifo_umbral
    import pcie_tl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] umbral_superior,
    input  logic [ADDR_WIDTH-1:0] umbral_inferior,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_valid;
    logic                  r_error;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_acc;
    logic                  w_push_acc;
    logic                  w_err_set;
    logic                  w_mem_wr_en;
    cnt_op_e               w_op;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Acceptance: a pop needs data already stored (no fall-through); a push into a
    // full FIFO is only allowed when a pop frees a slot in the same cycle.
    always_comb begin
        w_empty     = 1'b0;
        w_full      = 1'b0;
        w_pop_acc   = 1'b0;
        w_push_acc  = 1'b0;
        w_err_set   = 1'b0;
        w_mem_wr_en = 1'b0;
        w_op        = CNT_HOLD;
        w_count_nxt = r_count;

        w_empty    = (r_count == {(ADDR_WIDTH+1){1'b0}});
        w_full     = (r_count == DEPTH_C);
        w_pop_acc  = pop && !w_empty;
        w_push_acc = push && (!w_full || w_pop_acc);
        w_err_set  = (push && !w_push_acc) || (pop && !w_pop_acc);
        w_mem_wr_en = w_push_acc && !reset;
        w_op       = count_op(w_push_acc, w_pop_acc);

        case (w_op)
            CNT_INC:  w_count_nxt = r_count + ONE_C;
            CNT_DEC:  w_count_nxt = r_count - ONE_C;
            CNT_HOLD: w_count_nxt = r_count;
            default:  w_count_nxt = r_count;
        endcase
    end

    // Pointer, count, read-valid and sticky error state; reset overrides any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr <= {ADDR_WIDTH{1'b0}};
            r_count  <= {(ADDR_WIDTH+1){1'b0}};
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_valid <= w_pop_acc;
            r_error <= r_error | w_err_set;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (w_mem_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_pop_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    // Flags follow the registered count and the live thresholds (zero-extended, unsigned).
    always_comb begin
        empty        = 1'b0;
        full         = 1'b0;
        almost_full  = 1'b0;
        almost_empty = 1'b0;

        empty        = w_empty;
        full         = w_full;
        almost_full  = (r_count >= {1'b0, umbral_superior});
        almost_empty = (r_count <= {1'b0, umbral_inferior});
    end

    assign valid_out  = r_valid;
    assign fifo_count = r_count;
    assign error      = r_error;

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: scoreboard queue of pushed words, per-scenario tasks.
module tb_fifo_umbral;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [5:0] data_in = 6'd0;
    logic       pop = 1'b0;
    logic [2:0] umbral_superior = 3'd6;
    logic [2:0] umbral_inferior = 3'd2;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] fifo_count;
    logic       error;

    int         n_checks = 0;
    int         n_fail   = 0;

    logic [5:0] sb_q[$];
    int         m_count = 0;
    logic       m_err   = 1'b0;
    logic       m_valid = 1'b0;
    logic [5:0] m_data  = 6'd0;

    always #5 clk = ~clk;

    fifo_umbral dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .data_in         (data_in),
        .pop             (pop),
        .umbral_superior (umbral_superior),
        .umbral_inferior (umbral_inferior),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .empty           (empty),
        .full            (full),
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
        .fifo_count      (fifo_count),
        .error           (error)
    );

    // Drive one cycle of stimulus, advance the reference model, then sample 1 ns after the edge.
    task automatic tick(input logic r, input logic p, input logic [5:0] d, input logic q);
        bit pop_ok;
        bit push_ok;
        reset   = r;
        push    = p;
        data_in = d;
        pop     = q;
        if (r) begin
            sb_q.delete();
            m_count = 0;
            m_err   = 1'b0;
            m_valid = 1'b0;
            m_data  = 6'd0;
        end else begin
            pop_ok  = q && (m_count != 0);
            push_ok = p && ((m_count != 8) || pop_ok);
            m_valid = pop_ok;
            if (pop_ok) m_data = sb_q.pop_front();
            if (push_ok) sb_q.push_back(d);
            m_count = m_count + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
            if ((p && !push_ok) || (q && !pop_ok)) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic test_reset();
        umbral_superior = 3'd6;
        umbral_inferior = 3'd2;
        tick(1'b1, 1'b0, 6'd0, 1'b0);
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got %b want 1010", {empty, full, almost_empty, almost_full}); end
        n_checks++; if ({valid_out, error, data_out} !== 8'd0) begin n_fail++; $display("FAIL reset_outs: got valid=%b err=%b data=%0h want 0/0/0", valid_out, error, data_out); end
        umbral_superior = 3'd0;
        #1;
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL reset_af_thr0: got %b want 1", almost_full); end
        umbral_superior = 3'd6;
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b1, 6'(i), 1'b0);
            n_checks++; if (fifo_count !== 4'(i)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", fifo_count, i); end
            n_checks++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_almost_full: count %0d got %b", i, almost_full); end
            n_checks++; if (almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_almost_empty: count %0d got %b", i, almost_empty); end
        end
        n_checks++; if ({full, empty, error} !== 3'b100) begin n_fail++; $display("FAIL fill_end: got full=%b empty=%b err=%b want 1/0/0", full, empty, error); end
    endtask

    task automatic test_overflow_drain();
        tick(1'b0, 1'b1, 6'h3F, 1'b0);
        n_checks++; if (error !== 1'b1 || fifo_count !== 4'd8) begin n_fail++; $display("FAIL overflow: got err=%b count=%0d want 1/8", error, fifo_count); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 6'd0, 1'b1);
            n_checks++; if (valid_out !== m_valid || data_out !== m_data) begin n_fail++; $display("FAIL drain_data: got v=%b d=%0h want v=%b d=%0h", valid_out, data_out, m_valid, m_data); end
            n_checks++; if (data_out !== 6'(i + 1)) begin n_fail++; $display("FAIL drain_order: got %0h want %0h", data_out, i + 1); end
        end
        n_checks++; if (empty !== 1'b1 || fifo_count !== 4'd0 || error !== 1'b1) begin n_fail++; $display("FAIL drain_end: got empty=%b count=%0d err=%b want 1/0/1", empty, fifo_count, error); end
    endtask

    task automatic test_underflow();
        tick(1'b1, 1'b0, 6'd0, 1'b0);
        tick(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if ({valid_out, data_out} !== 7'd0) begin n_fail++; $display("FAIL underflow_out: got v=%b d=%0h want 0/0", valid_out, data_out); end
        n_checks++; if (error !== 1'b1 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL underflow_err: got err=%b count=%0d want 1/0", error, fifo_count); end
    endtask

    task automatic test_simul_empty();
        tick(1'b1, 1'b0, 6'd0, 1'b0);
        tick(1'b0, 1'b1, 6'h15, 1'b1);
        n_checks++; if (fifo_count !== 4'd1 || error !== 1'b1 || valid_out !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got count=%0d err=%b v=%b want 1/1/0", fifo_count, error, valid_out); end
        tick(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 6'h15) begin n_fail++; $display("FAIL simul_empty_pop: got v=%b d=%0h want 1/15", valid_out, data_out); end
    endtask

    task automatic test_full_pushpop();
        tick(1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 6'(8'h30 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 6'(8'h10 + i), 1'b1);
            n_checks++; if (fifo_count !== 4'd8 || full !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL fullpp_state: got count=%0d full=%b err=%b want 8/1/0", fifo_count, full, error); end
            n_checks++; if (valid_out !== 1'b1 || data_out !== m_data) begin n_fail++; $display("FAIL fullpp_data: got v=%b d=%0h want 1/%0h", valid_out, data_out, m_data); end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 6'd0, 1'b1);
            n_checks++; if (valid_out !== 1'b1 || data_out !== m_data) begin n_fail++; $display("FAIL fullpp_drain: got v=%b d=%0h want 1/%0h", valid_out, data_out, m_data); end
        end
    endtask

    task automatic test_wrap();
        umbral_inferior = 3'd2;
        tick(1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 6'(8'h20 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b1, 6'(8'h23 + i), 1'b0);
            tick(1'b0, 1'b0, 6'd0, 1'b1);
            n_checks++; if (valid_out !== 1'b1 || data_out !== m_data) begin n_fail++; $display("FAIL wrap_data: got v=%b d=%0h want 1/%0h", valid_out, data_out, m_data); end
        end
        n_checks++; if (fifo_count !== 4'd3 || almost_empty !== 1'b0) begin n_fail++; $display("FAIL wrap_count: got count=%0d ae=%b want 3/0", fifo_count, almost_empty); end
        umbral_inferior = 3'd4;
        #1;
        n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL thr_raise_ae: got %b want 1", almost_empty); end
        umbral_inferior = 3'd2;
        #1;
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 6'(8'h05 + i), 1'b0);
        n_checks++; if (fifo_count !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 5", fifo_count); end
        tick(1'b1, 1'b1, 6'h2A, 1'b0);
        n_checks++; if (fifo_count !== 4'd0 || empty !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL rstmid_post: got count=%0d empty=%b err=%b want 0/1/0", fifo_count, empty, error); end
        tick(1'b0, 1'b0, 6'd0, 1'b1);
        n_checks++; if (valid_out !== 1'b0 || error !== 1'b1) begin n_fail++; $display("FAIL rstmid_pop: got v=%b err=%b want 0/1", valid_out, error); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_simul_empty();
        test_full_pushpop();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Synchronous per-channel FIFO for the PCIe transaction layer, instantiated eight times upstream of the transaction-layer state machine. Each instance buffers transaction words for one virtual channel. Each drives one bit of that machine's `empties[7:0]` bus. Each compares its fill level against the `umbral_superior` / `umbral_inferior` thresholds the state machine latches at `init`, producing almost-full and almost-empty flags for the arbiter's flow control.

## Interface
Parameters:
- `DATA_WIDTH`, 6: width of a stored word.
- `ADDR_WIDTH`, 3: pointer width. Depth is 2^ADDR_WIDTH = 8. The threshold width equals ADDR_WIDTH.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `push`, in, 1: write request.
- `data_in`, in, DATA_WIDTH: word written on an accepted push.
- `pop`, in, 1: read request.
- `umbral_superior`, in, ADDR_WIDTH: almost-full threshold. Sampled every cycle.
- `umbral_inferior`, in, ADDR_WIDTH: almost-empty threshold. Sampled every cycle.
- `data_out`, out, DATA_WIDTH: registered read data.
- `valid_out`, out, 1: high for exactly the cycle after an accepted pop.
- `empty`, out, 1: count == 0. Feeds one `empties` bit.
- `full`, out, 1: count == 2^ADDR_WIDTH.
- `almost_full`, out, 1: count >= umbral_superior.
- `almost_empty`, out, 1: count <= umbral_inferior.
- `fifo_count`, out, ADDR_WIDTH+1: current occupancy, 0..8.
- `error`, out, 1: sticky overflow/underflow flag.

## Operation
- Storage is a register array of depth 2^ADDR_WIDTH. `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits and wrap naturally from 7 to 0.
- A push is accepted when `push` is high and either `full` is low, or `pop` is also accepted in the same cycle. On acceptance: mem[wr_ptr] <= data_in, then wr_ptr++.
- A pop is accepted when `pop` is high and `empty` is low. On acceptance: data_out <= mem[rd_ptr], then rd_ptr++, and valid_out <= 1. Otherwise valid_out <= 0 and data_out holds its value.
- There is no fall-through. A pop on an empty FIFO is rejected even if a push occurs in the same cycle.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both are accepted or neither is.
- Rejected push (full with no accepted pop): data is dropped, pointers are unchanged, and `error` <= 1.
- Rejected pop (empty): pointers are unchanged and `error` <= 1.
- `error` stays set until `reset`.
- Flags are combinational from the registered count and the current threshold inputs. All comparisons are unsigned on ADDR_WIDTH+1 bits, with thresholds zero-extended.
  - umbral_superior = 0 makes almost_full constantly 1.
  - umbral_inferior = 7 makes almost_empty 1 for counts 0..7.

## Timing
- Reset values:
  - data_out = 0, valid_out = 0, error = 0.
  - Pointers = 0, fifo_count = 0.
  - Hence empty = 1, full = 0, almost_empty = 1.
  - almost_full = (umbral_superior == 0).
  - Memory contents are not cleared.
- Reset has priority over push and pop in the same cycle. Reset mid-operation discards all contents.
- Write-to-read latency: a word pushed at edge N is poppable at edge N+1, with data_out/valid_out visible after that edge.
- Flags, empty and full change in the cycle after the causing push or pop edge. Threshold changes affect the flags combinationally within the same cycle.
- Simultaneous push and pop when full: both are accepted, count stays 8, full stays 1.
- Simultaneous push and pop when empty: the push is accepted, the pop is rejected, count goes to 1, and error is set.

## Structure
- Shared package `pcie_tl_pkg` holds the following, and the state machine imports the same values:
  - `FIFO_DATA_WIDTH` = 6, `FIFO_ADDR_WIDTH` = 3.
  - `NUM_FIFOS` = 8.
- One natural sub-module, `fifo_mem`: the register array with a synchronous write port and a registered read port.
- Pointer logic, count logic, flags and error tracking stay in `fifo_umbral`.

## Test plan
- Reset, then 8 pushes of 0x01..0x08 with thresholds 6/2 → count 8, full = 1, almost_full from count 6, almost_empty low from count 3, error = 0.
- 9th push of 0x3F while full → dropped, error = 1. Then 8 pops return 0x01..0x08 in order with valid_out each cycle, ending with empty = 1.
- Pop on empty after reset → valid_out = 0, data_out = 0, error = 1, count 0.
- Fill to 8, then push+pop together for 4 cycles → count stays 8, full stays 1, error = 0. Popped data is in FIFO order and pointers wrap.
- 12 push/pop pairs interleaved from count 3 (pointer wrap) → FIFO order preserved. Raise umbral_inferior from 2 to 4 at count 3 → almost_empty = 1 in the same cycle.
- Reset asserted with count 5 and push = 1 → next cycle count 0, empty = 1, error = 0. A following pop is rejected.
